// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the data-cache port arbiter.
package cache_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN} state_e;
    localparam int XLEN = 32;
    localparam int F3W  = 3;
    localparam logic [F3W-1:0] FUNC3_LB  = 3'b000;
    localparam logic [F3W-1:0] FUNC3_LH  = 3'b001;
    localparam logic [F3W-1:0] FUNC3_LW  = 3'b010;
    localparam logic [F3W-1:0] FUNC3_LBU = 3'b100;
    localparam logic [F3W-1:0] FUNC3_LHU = 3'b101;
    localparam logic [F3W-1:0] FUNC3_SB  = 3'b000;
    localparam logic [F3W-1:0] FUNC3_SH  = 3'b001;
    localparam logic [F3W-1:0] FUNC3_SW  = 3'b010;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker; on a tie the requester not served last wins.
module rr_pick2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       fixed_prio,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       pick
);
    logic last_q, last_d;
    always_comb begin
        last_d = update ? served : last_q;
        pick   = (&req) ? (!fixed_prio && !last_q) : req[1];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= 1'b0;
        else       last_q <= last_d;
    end
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: grants the cache port to one of two requesters and sequences
// issue / wait / completion, returning a one-cycle ack with data and error.
module cache_arbiter import cache_pkg::*; #(
    parameter int TIMEOUT    = 64,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            r0_req,
    input  logic [XLEN-1:0] r0_addr,
    input  logic [XLEN-1:0] r0_wdata,
    input  logic            r0_we,
    input  logic [F3W-1:0]  r0_func3,
    output logic            r0_ack,
    output logic [XLEN-1:0] r0_rdata,
    output logic            r0_err,
    input  logic            r1_req,
    input  logic [XLEN-1:0] r1_addr,
    input  logic [XLEN-1:0] r1_wdata,
    input  logic            r1_we,
    input  logic [F3W-1:0]  r1_func3,
    output logic            r1_ack,
    output logic [XLEN-1:0] r1_rdata,
    output logic            r1_err,
    output logic [XLEN-1:0] c_addr,
    output logic [XLEN-1:0] c_wdata,
    output logic [F3W-1:0]  c_func3,
    output logic            c_we,
    input  logic [XLEN-1:0] c_rdata,
    input  logic            c_hit,
    input  logic            c_busy
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    state_e          state_q, state_d;
    logic            win_q, win_d, to_q, to_d, we_q, we_d, err_q, err_d, pick, upd;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      ack_q, ack_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [F3W-1:0]  f3_q, f3_d;
    rr_pick2 u_pick (
        .clk       (clk),
        .reset     (reset),
        .fixed_prio(FIXED_PRIO),
        .req       ({r1_req, r0_req}),
        .update    (upd),
        .served    (win_q),
        .pick      (pick)
    );
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        we_d    = 1'b0;
        ack_d   = '0;
        rdata_d = '0;
        err_d   = 1'b0;
        upd     = 1'b0;
        case (state_q)
            S_IDLE: if (r0_req || r1_req) begin
                win_d   = pick;
                addr_d  = pick ? r1_addr  : r0_addr;
                wdata_d = pick ? r1_wdata : r0_wdata;
                f3_d    = pick ? r1_func3 : r0_func3;
                we_d    = pick ? r1_we    : r0_we;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            // A rejected access (busy low, hit low) and a timeout both complete with error.
            S_WAIT: if (!c_busy || cnt_q == CNT_LAST) begin
                ack_d[win_q] = 1'b1;
                rdata_d      = (!c_busy && c_hit) ? c_rdata : '0;
                err_d        = c_busy || !c_hit;
                to_d         = c_busy;
                state_d      = S_DONE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_DONE: begin
                upd     = 1'b1;
                state_d = to_q ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: state_d = c_busy ? S_DRAIN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            win_q   <= 1'b0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            ack_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
    assign c_addr   = addr_q;
    assign c_wdata  = wdata_q;
    assign c_func3  = f3_q;
    assign c_we     = we_q;
    assign r0_ack   = ack_q[0];
    assign r1_ack   = ack_q[1];
    assign r0_rdata = ack_q[0] ? rdata_q : '0;
    assign r1_rdata = ack_q[1] ? rdata_q : '0;
    assign r0_err   = ack_q[0] && err_q;
    assign r1_err   = ack_q[1] && err_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: scoreboard bench with a stub cache whose busy window is scheduled
// from the arbiter's issue timing; a second fixed-priority instance checks tie-breaking.
module tb_cache_arbiter;
    localparam int TO = 8;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
    logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
    logic [2:0] r0_func3 = 0, r1_func3 = 0;
    logic r0_ack, r0_err, r1_ack, r1_err, c_we, c_hit, c_busy;
    logic [31:0] r0_rdata, r1_rdata, c_addr, c_wdata, c_rdata;
    logic [2:0] c_func3;
    logic f0_req = 0, f1_req = 0;
    logic f0_ack, f0_err, f1_ack, f1_err, fc_we;
    logic [31:0] f0_rdata, f1_rdata, fc_addr, fc_wdata, fc_rdata;
    logic [2:0] fc_func3;
    logic stuck_busy = 0;
    int busy_from = 0, busy_to = 0;
    logic st_v = 0;
    logic [31:0] st_a = 0, st_d = 0;
    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction
    assign c_busy   = stuck_busy || (cyc >= busy_from && cyc < busy_to);
    assign c_hit    = !c_busy && (c_func3[1:0] == 2'b10 ? c_addr[1:0] == 2'b00 :
                                  c_func3[1:0] == 2'b01 ? !c_addr[0] : 1'b1);
    assign c_rdata  = (st_v && st_a[31:2] == c_addr[31:2]) ? st_d : pat(c_addr);
    assign fc_rdata = pat(fc_addr);
    always @(posedge clk) if (c_we) begin
        st_v <= 1'b1;
        st_a <= c_addr;
        st_d <= c_wdata;
    end
    cache_arbiter #(.TIMEOUT(TO), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_we(r0_we), .r0_func3(r0_func3),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_we(r1_we), .r1_func3(r1_func3),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_func3(c_func3), .c_we(c_we),
        .c_rdata(c_rdata), .c_hit(c_hit), .c_busy(c_busy)
    );
    cache_arbiter #(.TIMEOUT(TO), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset(reset),
        .r0_req(f0_req), .r0_addr(32'h10), .r0_wdata(32'h0), .r0_we(1'b0), .r0_func3(3'b010),
        .r0_ack(f0_ack), .r0_rdata(f0_rdata), .r0_err(f0_err),
        .r1_req(f1_req), .r1_addr(32'h20), .r1_wdata(32'h0), .r1_we(1'b0), .r1_func3(3'b010),
        .r1_ack(f1_ack), .r1_rdata(f1_rdata), .r1_err(f1_err),
        .c_addr(fc_addr), .c_wdata(fc_wdata), .c_func3(fc_func3), .c_we(fc_we),
        .c_rdata(fc_rdata), .c_hit(1'b1), .c_busy(1'b0)
    );
    typedef struct {logic id; logic [31:0] d; logic e; int c;} exp_t;
    exp_t sb[$];
    int nvec = 0, nerr = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic expect_ack(input logic id, input logic [31:0] d, input logic e, input int c);
        exp_t x;
        x = '{id, d, e, c};
        sb.push_back(x);
    endtask
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && (r0_ack || r1_ack)) begin
            if (r0_ack && r1_ack) check("dual_ack", 1, 0);
            else if (sb.size() == 0) check("spurious_ack", {r1_ack, r0_ack}, 0);
            else begin
                e = sb.pop_front();
                check("ack_id", r1_ack, e.id);
                check("rdata", e.id ? r1_rdata : r0_rdata, e.d);
                check("err", e.id ? r1_err : r0_err, e.e);
                check("ack_cyc", cyc, e.c);
                check("loser_quiet", e.id ? {r0_rdata, r0_err} : {r1_rdata, r1_err}, 0);
            end
        end
    end
    task automatic set_req(input logic id, input logic v, input logic [31:0] a, input logic [31:0] wd,
                           input logic we, input logic [2:0] f3);
        if (id) begin
            r1_req = v; r1_addr = a; r1_wdata = wd; r1_we = we; r1_func3 = f3;
        end else begin
            r0_req = v; r0_addr = a; r0_wdata = wd; r0_we = we; r0_func3 = f3;
        end
    endtask
    task automatic xact(input logic id, input logic [31:0] a, input logic [31:0] wd, input logic we,
                        input logic [2:0] f3, input int busy_n, input int lat,
                        input logic [31:0] ed, input logic ee);
        int k, we_n, we_at, bad;
        logic got;
        we_n = 0; we_at = -1; bad = 0; got = 0;
        @(negedge clk);
        k = cyc;
        if (busy_n > 0) begin
            busy_from = k + 2;
            busy_to   = k + 2 + busy_n;
        end
        set_req(id, 1, a, wd, we, f3);
        expect_ack(id, ed, ee, k + lat);
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (c_we) begin we_n++; we_at = cyc; end
            if (c_addr !== a) bad++;
            got = id ? r1_ack : r0_ack;
        end
        set_req(id, 0, a, wd, we, f3);
        check("ack_seen", got, 1);
        check("c_addr_stable", bad, 0);
        check("c_func3", c_func3, f3);
        check("c_wdata", c_wdata, wd);
        check("c_we_pulses", we_n, we);
        if (we) check("c_we_cycle", we_at, k + 1);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int k, n, n0, n1, c0;
        logic got;
        repeat (2) @(negedge clk);
        check("rst_c_addr", c_addr, 0);
        check("rst_c_we", c_we, 0);
        check("rst_acks", {r0_ack, r1_ack, f0_ack, f1_ack}, 0);
        check("rst_rdata", {r0_rdata, r1_rdata}, 0);
        reset = 1'b0;
        // tie from reset: r1, r0, r1, r0
        @(negedge clk);
        k = cyc;
        set_req(0, 1, 32'h100, 0, 0, 3'b010);
        set_req(1, 1, 32'h240, 0, 0, 3'b010);
        for (int i = 0; i < 4; i++) expect_ack(!i[0], pat(i[0] ? 32'h100 : 32'h240), 0, k + 3 + 4 * i);
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (r0_ack || r1_ack) n++;
        end
        set_req(0, 0, 32'h100, 0, 0, 3'b010);
        set_req(1, 0, 32'h240, 0, 0, 3'b010);
        check("rr_acks", n, 4);
        xact(0, 32'h100, 0, 0, 3'b010, 0, 3, pat(32'h100), 0);
        xact(1, 32'h240, 0, 0, 3'b010, 5, 8, pat(32'h240), 0);
        xact(0, 32'h40, 32'hDEADBEEF, 1, 3'b010, 2, 5, 32'hDEADBEEF, 0);
        xact(0, 32'h40, 0, 0, 3'b010, 0, 3, 32'hDEADBEEF, 0);
        xact(1, 32'h102, 0, 0, 3'b010, 0, 3, 0, 1);
        xact(1, 32'h103, 0, 0, 3'b100, 0, 3, pat(32'h103), 0);
        // timeout after TO wait cycles, then no grant until busy falls
        xact(0, 32'h80, 0, 0, 3'b010, 14, 2 + TO, 0, 1);
        set_req(1, 1, 32'h100, 0, 0, 3'b010);
        expect_ack(1, pat(32'h100), 0, busy_to + 4);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = r1_ack;
        end
        set_req(1, 0, 32'h100, 0, 0, 3'b010);
        check("drain_ack_seen", got, 1);
        // reset in the middle of WAIT drops the transaction
        @(negedge clk);
        stuck_busy = 1'b1;
        set_req(0, 1, 32'h300, 32'h55, 0, 3'b010);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_c_addr", c_addr, 0);
        check("midrst_c_func3", c_func3, 0);
        check("midrst_c_wdata", c_wdata, 0);
        check("midrst_acks", {r0_ack, r1_ack}, 0);
        @(negedge clk);
        reset = 1'b0;
        stuck_busy = 1'b0;
        set_req(0, 0, 32'h300, 0, 0, 3'b010);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (r0_ack || r1_ack) n++;
        end
        check("midrst_no_ack", n, 0);
        // fixed priority: r0 wins every tie until it drops
        @(negedge clk);
        f0_req = 1; f1_req = 1;
        n0 = 0; n1 = 0; c0 = 0;
        for (int i = 0; i < 60 && n1 == 0; i++) begin
            @(negedge clk);
            if (f0_ack) begin
                n0++; c0 = cyc;
                check("fp_r0_data", f0_rdata, pat(32'h10));
                if (n0 == 3) f0_req = 0;
            end
            if (f1_ack) begin
                n1++;
                f1_req = 0;
                check("fp_order", n0, 3);
                check("fp_period", cyc - c0, 4);
                check("fp_r1_data", f1_rdata, pat(32'h20));
            end
        end
        f0_req = 0; f1_req = 0;
        check("fp_r0_count", n0, 3);
        check("fp_r1_count", n1, 1);
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
